// File: rtl/alu_issue_stage.sv
// alu_issue_stage: ID/EX issue stage feeding the ALU.
// Resolves operand B (register or immediate), optionally forwards in-flight
// results onto both operands, masks sll shift amounts to 5 bits, and buffers
// up to two micro-ops in an output register plus skid register so that
// in_ready can come straight from a flop without losing throughput.
// Optional feature macro: ALU_ISSUE_FWD_EN enables EX/WB operand forwarding.
module alu_issue_stage #(
    parameter int XLEN   = 32,
    parameter int RIDX_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_rs1_val,
    input  logic [XLEN-1:0]   in_rs2_val,
    input  logic [RIDX_W-1:0] in_rs1_idx,
    input  logic [RIDX_W-1:0] in_rs2_idx,
    input  logic [RIDX_W-1:0] in_rd_idx,
    input  logic [XLEN-1:0]   in_imm,
    input  logic              in_use_imm,
    input  logic [3:0]        in_alu_sel,
    input  logic              ex_fwd_valid,
    input  logic [RIDX_W-1:0] ex_fwd_idx,
    input  logic [XLEN-1:0]   ex_fwd_data,
    input  logic              wb_fwd_valid,
    input  logic [RIDX_W-1:0] wb_fwd_idx,
    input  logic [XLEN-1:0]   wb_fwd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   opA,
    output logic [XLEN-1:0]   opB,
    output logic [3:0]        aluOutSel,
    output logic [RIDX_W-1:0] out_rd_idx
);

    localparam logic [3:0] SEL_SLL = 4'b0111;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t              state_q;
    logic                in_ready_q;
    logic                out_valid_q;
    logic [XLEN-1:0]     opa_q;
    logic [XLEN-1:0]     opb_q;
    logic [3:0]          sel_q;
    logic [RIDX_W-1:0]   rd_q;
    logic [XLEN-1:0]     skid_opa_q;
    logic [XLEN-1:0]     skid_opb_q;
    logic [3:0]          skid_sel_q;
    logic [RIDX_W-1:0]   skid_rd_q;

    logic                in_fire;
    logic                out_fire;
    logic [XLEN-1:0]     rs1_res;
    logic [XLEN-1:0]     rs2_res;
    logic [XLEN-1:0]     b_res;
    logic [XLEN-1:0]     opb_d;

    assign in_fire  = in_valid & in_ready_q;
    assign out_fire = out_valid_q & out_ready;

`ifndef ALU_ISSUE_FWD_EN
    // Forward buses and source indices only matter when forwarding is built in.
    logic unused_fwd;
    assign unused_fwd = ^{ex_fwd_valid, ex_fwd_idx, ex_fwd_data,
                          wb_fwd_valid, wb_fwd_idx, wb_fwd_data,
                          in_rs1_idx, in_rs2_idx};
`endif

    // Operand resolution at capture time: forwarding (EX over WB), immediate
    // select, then shift-amount masking for sll.
    always_comb begin
        rs1_res = in_rs1_val;
        rs2_res = in_rs2_val;
`ifdef ALU_ISSUE_FWD_EN
        // Register x0 is hardwired, so it never takes a forwarded value.
        if (in_rs1_idx != '0) begin
            if (wb_fwd_valid && (wb_fwd_idx == in_rs1_idx)) rs1_res = wb_fwd_data;
            if (ex_fwd_valid && (ex_fwd_idx == in_rs1_idx)) rs1_res = ex_fwd_data;
        end
        if (in_rs2_idx != '0) begin
            if (wb_fwd_valid && (wb_fwd_idx == in_rs2_idx)) rs2_res = wb_fwd_data;
            if (ex_fwd_valid && (ex_fwd_idx == in_rs2_idx)) rs2_res = ex_fwd_data;
        end
`endif
        b_res = in_use_imm ? in_imm : rs2_res;
        opb_d = b_res;
        // The ALU shifter iterates once per amount bit value, so cap it at 31.
        if (in_alu_sel == SEL_SLL) begin
            opb_d = {{(XLEN-5){1'b0}}, b_res[4:0]};
        end
    end

    // Occupancy FSM with output and skid registers; all handshake outputs are flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            opa_q       <= '0;
            opb_q       <= '0;
            sel_q       <= '0;
            rd_q        <= '0;
            skid_opa_q  <= '0;
            skid_opb_q  <= '0;
            skid_sel_q  <= '0;
            skid_rd_q   <= '0;
        end else if (flush) begin
            // Drop everything including any op offered this cycle; data regs keep values.
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        opa_q       <= rs1_res;
                        opb_q       <= opb_d;
                        sel_q       <= in_alu_sel;
                        rd_q        <= in_rd_idx;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        opa_q <= rs1_res;
                        opb_q <= opb_d;
                        sel_q <= in_alu_sel;
                        rd_q  <= in_rd_idx;
                    end else if (in_fire) begin
                        skid_opa_q <= rs1_res;
                        skid_opb_q <= opb_d;
                        skid_sel_q <= in_alu_sel;
                        skid_rd_q  <= in_rd_idx;
                        in_ready_q <= 1'b0;
                        state_q    <= ST_TWO;
                    end else if (out_fire) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (out_fire) begin
                        opa_q      <= skid_opa_q;
                        opb_q      <= skid_opb_q;
                        sel_q      <= skid_sel_q;
                        rd_q       <= skid_rd_q;
                        in_ready_q <= 1'b1;
                        state_q    <= ST_ONE;
                    end
                end
                default: begin
                    state_q     <= ST_EMPTY;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign opA        = opa_q;
    assign opB        = opb_q;
    assign aluOutSel  = sel_q;
    assign out_rd_idx = rd_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed vector table, hand-written
// backpressure/flush/async-reset sequences, and a randomized run against a
// queue-based reference model. Expectations adapt to ALU_ISSUE_FWD_EN.
module tb_alu_issue_stage;

`ifdef ALU_ISSUE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_rs1_val, in_rs2_val, in_imm;
    logic [4:0]  in_rs1_idx, in_rs2_idx, in_rd_idx;
    logic        in_use_imm;
    logic [3:0]  in_alu_sel;
    logic        ex_fwd_valid, wb_fwd_valid;
    logic [4:0]  ex_fwd_idx, wb_fwd_idx;
    logic [31:0] ex_fwd_data, wb_fwd_data;
    logic        out_valid, out_ready;
    logic [31:0] opA, opB;
    logic [3:0]  aluOutSel;
    logic [4:0]  out_rd_idx;

    int tests = 0;
    int fails = 0;

    alu_issue_stage #(.XLEN(32), .RIDX_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
        .in_rs1_idx(in_rs1_idx), .in_rs2_idx(in_rs2_idx), .in_rd_idx(in_rd_idx),
        .in_imm(in_imm), .in_use_imm(in_use_imm), .in_alu_sel(in_alu_sel),
        .ex_fwd_valid(ex_fwd_valid), .ex_fwd_idx(ex_fwd_idx), .ex_fwd_data(ex_fwd_data),
        .wb_fwd_valid(wb_fwd_valid), .wb_fwd_idx(wb_fwd_idx), .wb_fwd_data(wb_fwd_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .opA(opA), .opB(opB), .aluOutSel(aluOutSel), .out_rd_idx(out_rd_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rs1v, rs2v, imm;
        logic [4:0]  rs1i, rs2i, rdi;
        logic        use_imm;
        logic [3:0]  sel;
        logic        exv;
        logic [4:0]  exi;
        logic [31:0] exd;
        logic        wbv;
        logic [4:0]  wbi;
        logic [31:0] wbd;
        logic [31:0] ea, eb;
    } vec_t;

    typedef struct {
        logic [31:0] a, b;
        logic [3:0]  sel;
        logic [4:0]  rd;
    } op_t;

    vec_t vecs[11];
    op_t  model_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] rs1v, rs2v, imm,
                                input logic [4:0] rs1i, rs2i, rdi,
                                input logic use_imm, input logic [3:0] sel,
                                input logic exv, input logic [4:0] exi, input logic [31:0] exd,
                                input logic wbv, input logic [4:0] wbi, input logic [31:0] wbd,
                                input logic [31:0] ea, eb);
        vec_t v;
        v.rs1v = rs1v; v.rs2v = rs2v; v.imm = imm;
        v.rs1i = rs1i; v.rs2i = rs2i; v.rdi = rdi;
        v.use_imm = use_imm; v.sel = sel;
        v.exv = exv; v.exi = exi; v.exd = exd;
        v.wbv = wbv; v.wbi = wbi; v.wbd = wbd;
        v.ea = ea; v.eb = eb;
        return v;
    endfunction

    // Reference: value a source register reads as, given the forward buses.
    function automatic logic [31:0] src_val(input logic [4:0] idx, input logic [31:0] rf,
                                            input logic exv, input logic [4:0] exi, input logic [31:0] exd,
                                            input logic wbv, input logic [4:0] wbi, input logic [31:0] wbd);
        if (FWD && idx != 0 && exv && exi == idx) return exd;
        if (FWD && idx != 0 && wbv && wbi == idx) return wbd;
        return rf;
    endfunction

    function automatic op_t ref_op();
        op_t o;
        logic [31:0] b;
        o.a = src_val(in_rs1_idx, in_rs1_val, ex_fwd_valid, ex_fwd_idx, ex_fwd_data,
                      wb_fwd_valid, wb_fwd_idx, wb_fwd_data);
        b = in_use_imm ? in_imm
                       : src_val(in_rs2_idx, in_rs2_val, ex_fwd_valid, ex_fwd_idx, ex_fwd_data,
                                 wb_fwd_valid, wb_fwd_idx, wb_fwd_data);
        o.b   = (in_alu_sel == 4'd7) ? (b % 32) : b;
        o.sel = in_alu_sel;
        o.rd  = in_rd_idx;
        return o;
    endfunction

    task automatic idle();
        flush = 0; in_valid = 0; out_ready = 1;
        in_rs1_val = 0; in_rs2_val = 0; in_imm = 0;
        in_rs1_idx = 0; in_rs2_idx = 0; in_rd_idx = 0;
        in_use_imm = 0; in_alu_sel = 0;
        ex_fwd_valid = 0; ex_fwd_idx = 0; ex_fwd_data = 0;
        wb_fwd_valid = 0; wb_fwd_idx = 0; wb_fwd_data = 0;
    endtask

    task automatic apply(input vec_t v);
        in_rs1_val = v.rs1v; in_rs2_val = v.rs2v; in_imm = v.imm;
        in_rs1_idx = v.rs1i; in_rs2_idx = v.rs2i; in_rd_idx = v.rdi;
        in_use_imm = v.use_imm; in_alu_sel = v.sel;
        ex_fwd_valid = v.exv; ex_fwd_idx = v.exi; ex_fwd_data = v.exd;
        wb_fwd_valid = v.wbv; wb_fwd_idx = v.wbi; wb_fwd_data = v.wbd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Directed vectors: rs1v rs2v imm rs1i rs2i rdi use_imm sel exv exi exd wbv wbi wbd ea eb
        vecs[0]  = mk(32'd5, 32'd7, 0, 1, 2, 3, 0, 4'd0, 0, 0, 0, 0, 0, 0, 32'd5, 32'd7);
        vecs[1]  = mk(32'h1234, 0, 32'h25, 1, 2, 4, 1, 4'd7, 0, 0, 0, 0, 0, 0, 32'h1234, 32'h5);
        vecs[2]  = mk(32'h10, 32'hFFFFFFFF, 0, 1, 2, 5, 0, 4'd1, 0, 0, 0, 0, 0, 0, 32'h10, 32'hFFFFFFFF);
        vecs[3]  = mk(32'h1, 32'hFFFFFFE3, 0, 1, 2, 6, 0, 4'd7, 0, 0, 0, 0, 0, 0, 32'h1, 32'h3);
        vecs[4]  = mk(32'h11, 32'h2, 0, 3, 2, 7, 0, 4'd2, 1, 3, 32'hAA, 1, 3, 32'hBB,
                      FWD ? 32'hAA : 32'h11, 32'h2);
        vecs[5]  = mk(32'h11, 32'h2, 0, 3, 2, 8, 0, 4'd3, 0, 3, 32'hAA, 1, 3, 32'hBB,
                      FWD ? 32'hBB : 32'h11, 32'h2);
        vecs[6]  = mk(32'h77, 32'h8, 0, 0, 0, 9, 0, 4'd4, 1, 0, 32'hCC, 1, 0, 32'hDD,
                      32'h77, 32'h8);
        vecs[7]  = mk(32'h1, 32'h9, 0, 1, 4, 10, 0, 4'd5, 0, 0, 0, 1, 4, 32'h55,
                      32'h1, FWD ? 32'h55 : 32'h9);
        vecs[8]  = mk(32'h1, 32'h9, 32'h123, 1, 4, 11, 1, 4'd6, 1, 4, 32'hEE, 0, 0, 0,
                      32'h1, 32'h123);
        vecs[9]  = mk(32'hA5A5A5A5, 32'hFFFFFF00, 0, 1, 2, 12, 0, 4'b1010, 0, 0, 0, 0, 0, 0,
                      32'hA5A5A5A5, 32'hFFFFFF00);
        vecs[10] = mk(32'h2, 32'h21, 0, 1, 6, 13, 0, 4'd7, 1, 6, 32'h3F, 0, 0, 0,
                      32'h2, FWD ? 32'h1F : 32'h1);

        idle();
        rst_n = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_opA", opA, 0);
        chk("reset_opB", opB, 0);
        chk("reset_sel", aluOutSel, 0);
        chk("reset_rd", out_rd_idx, 0);
        tick();

        // Table: single op from EMPTY, visible next cycle, gone the cycle after.
        for (int i = 0; i < 11; i++) begin
            apply(vecs[i]);
            in_valid = 1;
            tick();
            in_valid = 0;
            chk("vec_out_valid", out_valid, 1);
            chk("vec_opA", opA, vecs[i].ea);
            chk("vec_opB", opB, vecs[i].eb);
            chk("vec_sel", aluOutSel, vecs[i].sel);
            chk("vec_rd", out_rd_idx, vecs[i].rdi);
            $display("[TB] vec %0d: opA=%h opB=%h sel=%h", i, opA, opB, aluOutSel);
            tick();
            chk("vec_drained", out_valid, 0);
        end
        idle();

        // Backpressure: three ops with out_ready low, then drain in order.
        out_ready = 0;
        in_valid = 1; in_rs1_val = 1; in_rd_idx = 1;
        tick();
        chk("bp_ready_after1", in_ready, 1);
        in_rs1_val = 2; in_rd_idx = 2;
        tick();
        chk("bp_ready_after2", in_ready, 0);
        chk("bp_head", opA, 1);
        in_rs1_val = 3; in_rd_idx = 3;
        tick();
        chk("bp_hold_valid", out_valid, 1);
        chk("bp_hold_opA", opA, 1);
        chk("bp_hold_rd", out_rd_idx, 1);
        out_ready = 1;
        tick();
        chk("bp_op2", opA, 2);
        chk("bp_ready_back", in_ready, 1);
        tick();
        in_valid = 0;
        chk("bp_op3", opA, 3);
        chk("bp_op3_valid", out_valid, 1);
        tick();
        chk("bp_empty", out_valid, 0);
        $display("[TB] backpressure sequence done");

        // Flush while TWO with an op offered in the flush cycle.
        out_ready = 0;
        in_valid = 1; in_rs1_val = 32'h10;
        tick();
        in_rs1_val = 32'h20;
        tick();
        chk("fl_two", in_ready, 0);
        flush = 1; in_rs1_val = 32'h30;
        tick();
        flush = 0; in_valid = 0; out_ready = 1;
        chk("fl_out_valid", out_valid, 0);
        chk("fl_in_ready", in_ready, 1);
        chk("fl_data_kept", opA, 32'h10);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("fl_stays_empty", out_valid, 0);
        end
        $display("[TB] flush sequence done");

        // Randomized run against the FIFO reference model.
        model_q.delete();
        for (int c = 0; c < 400; c++) begin
            bit do_in, do_out;
            op_t e;
            chk("rnd_out_valid", out_valid, model_q.size() > 0);
            chk("rnd_in_ready", in_ready, model_q.size() < 2);
            if (model_q.size() > 0) begin
                chk("rnd_opA", opA, model_q[0].a);
                chk("rnd_opB", opB, model_q[0].b);
                chk("rnd_sel", aluOutSel, model_q[0].sel);
                chk("rnd_rd", out_rd_idx, model_q[0].rd);
            end
            in_valid     = ($urandom_range(0, 3) != 0);
            out_ready    = ($urandom_range(0, 2) != 0);
            flush        = ($urandom_range(0, 39) == 0);
            in_rs1_val   = $urandom;
            in_rs2_val   = $urandom;
            in_imm       = $urandom;
            in_rs1_idx   = 5'($urandom_range(0, 3));
            in_rs2_idx   = 5'($urandom_range(0, 3));
            in_rd_idx    = 5'($urandom);
            in_use_imm   = $urandom_range(0, 1);
            in_alu_sel   = ($urandom_range(0, 2) == 0) ? 4'd7 : 4'($urandom);
            ex_fwd_valid = $urandom_range(0, 1);
            ex_fwd_idx   = 5'($urandom_range(0, 3));
            ex_fwd_data  = $urandom;
            wb_fwd_valid = $urandom_range(0, 1);
            wb_fwd_idx   = 5'($urandom_range(0, 3));
            wb_fwd_data  = $urandom;
            e      = ref_op();
            do_in  = in_valid && (model_q.size() < 2);
            do_out = out_ready && (model_q.size() > 0);
            if (flush) begin
                model_q.delete();
            end else begin
                if (do_out) begin
                    $display("[TB] rnd cycle %0d: out opA=%h opB=%h sel=%h", c, opA, opB, aluOutSel);
                    void'(model_q.pop_front());
                end
                if (do_in) model_q.push_back(e);
            end
            tick();
        end
        idle();
        tick();
        tick();
        chk("rnd_drained", out_valid, 0);

        // Async reset mid-stream: outputs clear without a clock edge.
        out_ready = 0;
        in_valid = 1; in_rs1_val = 32'hDEAD;
        tick();
        in_valid = 0;
        chk("ar_loaded", opA, 32'hDEAD);
        #2 rst_n = 0;
        #1;
        chk("ar_out_valid", out_valid, 0);
        chk("ar_opA", opA, 0);
        chk("ar_in_ready", in_ready, 1);
        tick();
        rst_n = 1;
        out_ready = 1;
        tick();
        chk("ar_stays_empty", out_valid, 0);
        $display("[TB] async reset sequence done");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

ID/EX issue stage directly upstream of the ALU: accepts decoded ALU micro-ops from the decoder, resolves operand B (register or immediate), forwards in-flight results onto both operands, and presents registered `opA`/`opB`/`aluOutSel` to the ALU. A two-entry skid buffer with valid/ready handshake on both sides gives full throughput while keeping `in_ready` registered. The stage also masks shift amounts so the iterative left shifter in the ALU never runs more than 31 steps.

## Interface
- `XLEN`, 32, datapath width
- `RIDX_W`, 5, register index width
- `clk` in 1: rising-edge clock
- `rst_n` in 1: asynchronous active-low reset
- `flush` in 1: synchronous pipeline flush
- `in_valid` in 1: decoder micro-op valid
- `in_ready` out 1: stage can accept (registered)
- `in_rs1_val`, `in_rs2_val` in XLEN: register-file read data
- `in_rs1_idx`, `in_rs2_idx`, `in_rd_idx` in RIDX_W: source/destination indices
- `in_imm` in XLEN: sign-extended immediate
- `in_use_imm` in 1: select `in_imm` as operand B
- `in_alu_sel` in 4: ALU op (0000 add, 0001 sub, 0010 xor, 0011 or, 0100 and, 0101 slt, 0110 sltu, 0111 sll)
- `ex_fwd_valid` in 1, `ex_fwd_idx` in RIDX_W, `ex_fwd_data` in XLEN: ALU-result forward
- `wb_fwd_valid` in 1, `wb_fwd_idx` in RIDX_W, `wb_fwd_data` in XLEN: writeback forward
- `out_valid` out 1: ALU operands valid
- `out_ready` in 1: downstream accepts
- `opA`, `opB` out XLEN: ALU operands
- `aluOutSel` out 4: ALU op select
- `out_rd_idx` out RIDX_W: destination index travelling with the op

## Operation
- Input fire = `in_valid & in_ready`; output fire = `out_valid & out_ready`.
- Operand resolution at capture: A = rs1 value; B = `in_imm` if `in_use_imm`, else rs2 value.
- Forwarding per source: EX match beats WB match; match needs fwd valid, index equal, index ≠ 0. Index 0 always reads `in_*_val` unchanged. B forwarding is suppressed when `in_use_imm=1`.
- Shift masking: for `in_alu_sel=0111`, the stored `opB` = resolved B & 0x1F. Other ops are passed at full width; `aluOutSel` values 1000–1111 are passed through unchanged.
- Entries snapshot at capture. Held entries do not re-snoop the forward buses.
- States: EMPTY (no entry), ONE (output reg valid, skid empty), TWO (both valid).
- Transitions:
  - EMPTY + in fire → ONE.
  - ONE + in fire + out fire → ONE, new op loaded into the output reg.
  - ONE + in fire without out fire → TWO, new op goes to the skid.
  - ONE + out fire only → EMPTY.
  - TWO + out fire → ONE, skid moves to the output reg.
  - `in_ready=0` in TWO, so no input fire is possible there.
- `in_ready` = 1 in EMPTY/ONE, 0 in TWO, and comes from a register.
- Ordering is strict FIFO; no op is dropped or duplicated except on flush.

## Timing
- Reset (async assert, sync-released use):
  - `out_valid`=0, `in_ready`=1.
  - `opA`=`opB`=0, `aluOutSel`=0000, `out_rd_idx`=0.
  - State = EMPTY.
- Latency: input fire in cycle N → `out_valid`=1 with its operands in cycle N+1 (from EMPTY, or from ONE with concurrent out fire).
- Throughput: 1 op/cycle while `out_ready`=1.
- Outputs hold stable while `out_valid & !out_ready`.
- `flush`=1 in cycle N: both entries are discarded; any input fire in N is ignored; cycle N+1 has `out_valid`=0, `in_ready`=1, state EMPTY. Data outputs keep their last values.
- Reset mid-operation: all entries are lost immediately; outputs go to their reset values asynchronously.

## Configuration
- `ALU_ISSUE_FWD_EN` defined: EX/WB forwarding logic is present as above.
- `ALU_ISSUE_FWD_EN` undefined: operands come only from `in_rs*_val`/`in_imm`. The `ex_fwd_*`/`wb_fwd_*` ports remain but are ignored. Shift masking, the handshake and flush are unchanged.

## Test plan
- Reset, then one op: add, rs1 val 5, rs2 val 7, `out_ready`=1 → next cycle `out_valid`=1, `opA`=5, `opB`=7, `aluOutSel`=0000; the following cycle `out_valid`=0.
- sll with `in_use_imm`=1, imm 0x00000025 → `opB`=0x00000005. sub with rs2 0xFFFFFFFF → `opB`=0xFFFFFFFF.
- Forwarding: rs1_idx=3, EX fwd idx 3 data 0xAA, WB fwd idx 3 data 0xBB → `opA`=0xAA. Same with EX invalid → `opA`=0xBB. rs1_idx=0 with fwd idx 0 → `opA`=`in_rs1_val`. Without the macro → `opA`=`in_rs1_val`.
- Backpressure: stream ops 1,2,3 with `out_ready`=0 → `in_ready` drops after the second accept. Then `out_ready`=1 → ops 1,2,3 emerge in order, no loss, one per cycle.
- Flush while in TWO with `in_valid`=1 → next cycle `out_valid`=0, `in_ready`=1; neither held op nor the flush-cycle op ever appears at the output.
- Async `rst_n` low mid-stream → `out_valid`=0 and `opA`=0 immediately, without waiting for a clock edge.
